// File: rtl/sid_bus_fifo.sv
// sid_bus_fifo: decodes SPI command bytes into SID register writes, queues them
// in a FIFO and issues one queued write per SID clock-enable to the addressed chip.
// Optional feature macro: SID_BUS_TIMEOUT_EN. When it is defined, a data byte is
// accepted only while a header is pending, and a header expires after TIMEOUT cycles.
module sid_bus_fifo #(
  parameter int N_SID   = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1200
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               SPI_DATA,
  input  logic                     SPI_RECV,
  input  logic                     CLKen,
  output logic [N_SID-1:0]         WR,
  output logic [4:0]               ADDR,
  output logic [7:0]               DATAW,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW
);
  localparam int CW = (N_SID > 1) ? $clog2(N_SID) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 13 + CW;

  // Reject parameter values the datapath is not built for.
  if (N_SID < 1 || N_SID > 8) begin : g_bad_n_sid
    $error("sid_bus_fifo: N_SID must be 1..8");
  end
  if (DEPTH < 2 || DEPTH > 256 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sid_bus_fifo: DEPTH must be a power of two in 2..256");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sid_bus_fifo: TIMEOUT must be at least 1");
  end

  // Byte classification
  logic is_hdr, is_data, is_cs;
  assign is_hdr  = SPI_RECV && SPI_DATA[7];
  assign is_data = SPI_RECV && (SPI_DATA[7:6] == 2'b00);
  assign is_cs   = SPI_RECV && (SPI_DATA[7:6] == 2'b01);

  logic [CW-1:0] chip_q, chip_d;
  logic [4:0]    hdr_addr_q, hdr_addr_d;
  logic [1:0]    dmsb_q, dmsb_d;
  logic          push_req;

  // Latch header fields and the sticky chip select; out-of-range selects are ignored.
  always_comb begin
    chip_d     = chip_q;
    hdr_addr_d = hdr_addr_q;
    dmsb_d     = dmsb_q;
    if (is_hdr) begin
      hdr_addr_d = SPI_DATA[6:2];
      dmsb_d     = SPI_DATA[1:0];
    end
    if (is_cs && (int'(SPI_DATA[2:0]) < N_SID)) begin
      chip_d = SPI_DATA[CW-1:0];
    end
  end

  // Decoder state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chip_q     <= '0;
      hdr_addr_q <= '0;
      dmsb_q     <= '0;
    end else begin
      chip_q     <= chip_d;
      hdr_addr_q <= hdr_addr_d;
      dmsb_q     <= dmsb_d;
    end
  end

`ifdef SID_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          pending_q, pending_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // A header arms pending; it is consumed by a data byte or expires after TIMEOUT cycles.
  always_comb begin
    pending_d = pending_q;
    tmo_cnt_d = tmo_cnt_q;
    if (is_hdr) begin
      pending_d = 1'b1;
      tmo_cnt_d = '0;
    end else if (is_data) begin
      pending_d = 1'b0;
    end else if (pending_q) begin
      if (tmo_cnt_q == TW'(TIMEOUT - 1)) pending_d = 1'b0;
      else                               tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Pending/timeout register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign push_req = is_data && pending_q;
`else
  // Legacy behaviour: every data byte reuses the last header.
  assign push_req = is_data;
`endif

  // FIFO storage and pointers
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, push_ok;
  logic [EW-1:0] wr_entry, head;
  logic [CW-1:0] head_chip;

  assign wr_entry  = {chip_q, hdr_addr_q, dmsb_q, SPI_DATA[5:0]};
  assign head      = mem[rptr_q];
  assign head_chip = head[EW-1:13];
  assign pop       = CLKen && (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  // The pop frees a slot this cycle, so a push into a full FIFO still fits.
  assign push_ok   = push_req && (!full || pop);

  // Pointer, occupancy and overflow next-state
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push_ok) level_d = level_q - 1'b1;
    if (push_req && full && !pop) overflow_d = 1'b1;
  end

  // Entry storage; not reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr_q] <= wr_entry;
  end

  // Write-issue outputs: one-hot strobe for the popped entry's chip
  logic [N_SID-1:0] wr_q, wr_d;
  logic [4:0]       addr_out_q, addr_out_d;
  logic [7:0]       dataw_q, dataw_d;

  for (genvar gi = 0; gi < N_SID; gi++) begin : g_wr
    assign wr_d[gi] = pop && (head_chip == CW'(gi));
  end

  // Address/data hold until the next pop.
  always_comb begin
    addr_out_d = addr_out_q;
    dataw_d    = dataw_q;
    if (pop) begin
      addr_out_d = head[12:8];
      dataw_d    = head[7:0];
    end
  end

  // FIFO control and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      addr_out_q <= '0;
      dataw_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      addr_out_q <= addr_out_d;
      dataw_q    <= dataw_d;
    end
  end

  assign WR       = wr_q;
  assign ADDR     = addr_out_q;
  assign DATAW    = dataw_q;
  assign LEVEL    = level_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_sid_bus_fifo.sv
// Self-checking bench for sid_bus_fifo: directed scenarios plus random byte
// streams, compared each cycle against a queue-based model of the command set.
module tb_sid_bus_fifo;
  localparam int N_SID   = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 1200;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [7:0]       SPI_DATA = 8'h00;
  logic             SPI_RECV = 1'b0;
  logic             CLKen = 1'b0;
  logic [N_SID-1:0] WR;
  logic [4:0]       ADDR;
  logic [7:0]       DATAW;
  logic [LW-1:0]    LEVEL;
  logic             OVERFLOW;

  always #5 CLK = ~CLK;

  sid_bus_fifo #(.N_SID(N_SID), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .SPI_DATA(SPI_DATA), .SPI_RECV(SPI_RECV),
    .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATAW(DATAW), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of entries encoded as chip*8192 + addr*256 + data
  int  q[$];
  int  m_chip, m_addr, m_dmsb;
  bit  m_ovf;
  int  e_wr, e_addr, e_data;
  longint cyc = 0;
  bit  chk_en = 1'b0;
`ifdef SID_BUS_TIMEOUT_EN
  bit     m_pending;
  longint hdr_cyc;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_chip = 0; m_addr = 0; m_dmsb = 0; m_ovf = 1'b0;
    e_wr = 0; e_addr = 0; e_data = 0;
`ifdef SID_BUS_TIMEOUT_EN
    m_pending = 1'b0;
    hdr_cyc = 0;
`endif
  endfunction

  // One clock of behaviour: pop the existing head first, then decode the byte.
  function automatic void model_step(input bit r, input logic [7:0] d, input bit ce);
    bit accept;
    int h;
    cyc++;
    e_wr = 0;
    if (ce && q.size() > 0) begin
      h = q.pop_front();
      e_wr   = 1 << (h / 8192);
      e_addr = (h / 256) % 32;
      e_data = h % 256;
    end
    if (r) begin
      if (d >= 8'h80) begin
        m_addr = (int'(d) / 4) % 32;
        m_dmsb = int'(d) % 4;
`ifdef SID_BUS_TIMEOUT_EN
        m_pending = 1'b1;
        hdr_cyc = cyc;
`endif
      end else if (d < 8'h40) begin
        accept = 1'b1;
`ifdef SID_BUS_TIMEOUT_EN
        accept = m_pending && ((cyc - hdr_cyc) <= TIMEOUT);
        m_pending = 1'b0;
`endif
        if (accept) begin
          if (q.size() < DEPTH) q.push_back(m_chip * 8192 + m_addr * 256 + m_dmsb * 64 + int'(d));
          else m_ovf = 1'b1;
        end
      end else if ((int'(d) % 8) < N_SID) begin
        m_chip = int'(d) % 8;
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("WR", WR, e_wr);
      chk("ADDR", ADDR, e_addr);
      chk("DATAW", DATAW, e_data);
      chk("LEVEL", LEVEL, q.size());
      chk("OVERFLOW", OVERFLOW, m_ovf);
      if (WR != '0) $display("issue t=%0t wr=%b addr=%02h data=%02h level=%0d", $time, WR, ADDR, DATAW, LEVEL);
    end
  end

  task automatic step(input bit r, input logic [7:0] d, input bit ce);
    @(negedge CLK); #1;
    SPI_RECV = r; SPI_DATA = d; CLKen = ce;
    model_step(r, d, ce);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    chk_en = 1'b0;
    RST_N = 1'b0; SPI_RECV = 1'b0; CLKen = 1'b0;
    model_reset();
    #1;
    chk("rst_wr", WR, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_dataw", DATAW, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_overflow", OVERFLOW, 0);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("init_wr", WR, 0);
    chk("init_level", LEVEL, 0);
    chk("init_overflow", OVERFLOW, 0);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1'b1;

    // Basic write to chip 0
    step(1'b1, 8'hE3, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    chk("t1_level_push", LEVEL, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_wr", WR, 1);
    chk("t1_addr", ADDR, 5'h18);
    chk("t1_dataw", DATAW, 8'hCF);
    chk("t1_level_pop", LEVEL, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_wr_single", WR, 0);

    // Chip select, then an out-of-range select that must be ignored
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h84, 1'b0);
    step(1'b1, 8'h25, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_wr", WR, 2);
    chk("t2_addr", ADDR, 5'h01);
    chk("t2_dataw", DATAW, 8'h25);
    step(1'b1, 8'h47, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_chip_kept", WR, 2);
    step(1'b1, 8'h40, 1'b0);

    // Overflow: DEPTH+1 writes with no CLKen, then drain in order
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 8'h80 | 8'((i % 32) << 2), 1'b0);
      step(1'b1, 8'(i), 1'b0);
    end
    chk("t3_level_full", LEVEL, DEPTH);
    chk("t3_overflow", OVERFLOW, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i == 0) begin
        chk("t3_first_addr", ADDR, 0);
        chk("t3_first_dataw", DATAW, 0);
      end
      if (i == DEPTH - 1) begin
        chk("t3_last_addr", ADDR, DEPTH - 1);
        chk("t3_last_dataw", DATAW, DEPTH - 1);
      end
      step(1'b0, 8'h00, 1'b0);
    end
    chk("t3_level_empty", LEVEL, 0);
    chk("t3_overflow_sticky", OVERFLOW, 1);

    // Push and pop together while full: accepted, no overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'h80 | 8'(((i + 1) % 32) << 2), 1'b0);
      step(1'b1, 8'(8'h20 + i), 1'b0);
    end
    step(1'b1, 8'hFC, 1'b0);
    step(1'b1, 8'h3F, 1'b1);
    chk("t4_level", LEVEL, DEPTH);
    chk("t4_overflow", OVERFLOW, 0);
    repeat (DEPTH) step(1'b0, 8'h00, 1'b1);
    chk("t4_last_addr", ADDR, 31);
    chk("t4_last_dataw", DATAW, 8'h3F);

    // Reset with five entries queued
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h80 | 8'((i + 3) << 2), 1'b0);
      step(1'b1, 8'(i + 1), 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t5_level_before", LEVEL, 5);
    chk("t5_addr_before", ADDR, 3);
    do_reset();
    repeat (20) step(1'b0, 8'h00, 1'b1);
    chk("t5_level_after", LEVEL, 0);

    // Header age: 1201 cycles (expired when timeout enabled), then 1200 (still valid)
    step(1'b1, 8'hA1, 1'b0);
    repeat (TIMEOUT) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h05, 1'b0);
`ifdef SID_BUS_TIMEOUT_EN
    chk("t6_stale_level", LEVEL, 0);
`else
    chk("t6_stale_level", LEVEL, 1);
`endif
    step(1'b1, 8'hA2, 1'b0);
    repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h06, 1'b0);
`ifdef SID_BUS_TIMEOUT_EN
    chk("t6_fresh_level", LEVEL, 1);
`else
    chk("t6_fresh_level", LEVEL, 2);
`endif
    chk("t6_overflow", OVERFLOW, 0);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Random byte streams with alternating drain rates and one mid-run reset
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit ce;
      int kind;
      logic [7:0] b;
      if (i == 2000) do_reset();
      r = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 9);
      if (kind < 3)      b = 8'h80 | 8'($urandom_range(0, 127));
      else if (kind < 8) b = 8'($urandom_range(0, 63));
      else               b = 8'h40 | 8'($urandom_range(0, 63));
      if (((i / 500) % 2) == 0) ce = ($urandom_range(0, 7) == 0);
      else                      ce = ($urandom_range(0, 1) == 1);
      step(r, b, ce);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
